// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcodes, the result returned
// for unknown opcodes, and the per-requester response slot state.
package alu_arbiter_pkg;

    localparam int ALUOP_WIDTH = 4;

    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD  = 4'd0;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUB  = 4'd1;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_AND  = 4'd2;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_OR   = 4'd3;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_XOR  = 4'd4;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLT  = 4'd5;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLTU = 4'd6;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLL  = 4'd7;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SRL  = 4'd8;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SRA  = 4'd9;

    // Result returned for any opcode the ALU does not implement.
    localparam logic [31:0] ALU_BAD_RESULT = 32'hEBADF00D;

    // Response slot: EMPTY until a result is captured, FULL until drained.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Unknown opcodes yield ALU_BAD_RESULT.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [ALUOP_WIDTH-1:0] i_op,
    input  logic [31:0]            i_a,
    input  logic [31:0]            i_b,
    output logic [31:0]            o_result
);

    // Opcode decode and result select.
    always_comb begin
        o_result = ALU_BAD_RESULT;
        case (i_op)
            ALUOP_ADD:  o_result = i_a + i_b;
            ALUOP_SUB:  o_result = i_a - i_b;
            ALUOP_AND:  o_result = i_a & i_b;
            ALUOP_OR:   o_result = i_a | i_b;
            ALUOP_XOR:  o_result = i_a ^ i_b;
            ALUOP_SLT:  o_result = {31'd0, ($signed(i_a) < $signed(i_b))};
            ALUOP_SLTU: o_result = {31'd0, (i_a < i_b)};
            ALUOP_SLL:  o_result = i_a << i_b[4:0];
            ALUOP_SRL:  o_result = i_a >> i_b[4:0];
            ALUOP_SRA:  o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
            default:    o_result = ALU_BAD_RESULT;
        endcase
    end

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: returns the first eligible index at or
// after the pointer, wrapping N-1 -> 0, as both a one-hot and an index.
module alu_rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_grant_idx,
    output logic             o_grant_any
);

    // Scan N candidates starting at the pointer; first eligible wins.
    always_comb begin
        int idx;
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        idx         = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(i_ptr) + i) % N;
            if (!o_grant_any && i_eligible[idx]) begin
                o_grant_any      = 1'b1;
                o_grant[idx]     = 1'b1;
                o_grant_idx      = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters. One request is accepted
// per cycle; its result lands in that requester's response slot next edge.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the requester keeps op/a/b stable while valid && !ready.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NREQ-1:0]             i_req_valid,
    output logic [NREQ-1:0]             o_req_ready,
    input  logic [NREQ*ALUOP_WIDTH-1:0] i_req_op,
    input  logic [NREQ*32-1:0]          i_req_a,
    input  logic [NREQ*32-1:0]          i_req_b,
    output logic [NREQ-1:0]             o_rsp_valid,
    input  logic [NREQ-1:0]             i_rsp_ready,
    output logic [NREQ*32-1:0]          o_rsp_data,
    output logic                        o_busy
);

    localparam int PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;

    slot_state_e            slot_q [NREQ];
    slot_state_e            slot_d [NREQ];
    logic [NREQ*32-1:0]     rsp_data_q, rsp_data_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       pick_ptr, grant_idx;
    logic [NREQ-1:0]        rsp_valid, eligible, grant;
    logic                   grant_any, accept;
    logic [ALUOP_WIDTH-1:0] alu_op;
    logic [31:0]            alu_a, alu_b, alu_result;

    // Slot state decoded to a valid bit per requester.
    always_comb begin
        rsp_valid = '0;
        for (int k = 0; k < NREQ; k++) begin
            rsp_valid[k] = (slot_q[k] == SLOT_FULL);
        end
    end

    // A requester may be granted if its slot is empty or being drained now.
    assign eligible = i_req_valid & (~rsp_valid | i_rsp_ready);
    assign pick_ptr = FIXED_PRIO ? '0 : ptr_q;

    alu_rr_pick #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_eligible  (eligible),
        .i_ptr       (pick_ptr),
        .o_grant     (grant),
        .o_grant_idx (grant_idx),
        .o_grant_any (grant_any)
    );

    // No acceptance while reset is held, so ready stays low during reset.
    assign accept = grant_any & i_rst_n;

    // Grant index is 0 when nobody is granted, so the ALU then sees requester 0.
    assign alu_op = i_req_op[int'(grant_idx)*ALUOP_WIDTH +: ALUOP_WIDTH];
    assign alu_a  = i_req_a[int'(grant_idx)*32 +: 32];
    assign alu_b  = i_req_b[int'(grant_idx)*32 +: 32];

    alu u_alu (
        .i_op     (alu_op),
        .i_a      (alu_a),
        .i_b      (alu_b),
        .o_result (alu_result)
    );

    // State register: slots, captured results and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                slot_q[k] <= SLOT_EMPTY;
            end
            rsp_data_q <= '0;
            ptr_q      <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                slot_q[k] <= slot_d[k];
            end
            rsp_data_q <= rsp_data_d;
            ptr_q      <= ptr_d;
        end
    end

    // Next state: accept fills a slot (replacing data on drain+accept),
    // drain alone empties it; pointer moves past the grantee.
    always_comb begin
        ptr_d      = ptr_q;
        rsp_data_d = rsp_data_q;
        for (int k = 0; k < NREQ; k++) begin
            slot_d[k] = slot_q[k];
            case (slot_q[k])
                SLOT_EMPTY: if (accept && grant[k]) slot_d[k] = SLOT_FULL;
                SLOT_FULL: begin
                    if (accept && grant[k])  slot_d[k] = SLOT_FULL;
                    else if (i_rsp_ready[k]) slot_d[k] = SLOT_EMPTY;
                end
                default: slot_d[k] = SLOT_EMPTY;
            endcase
        end
        if (accept) begin
            rsp_data_d[int'(grant_idx)*32 +: 32] = alu_result;
            ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Outputs: combinational ready, registered response, busy summary.
    always_comb begin
        o_req_ready = grant & {NREQ{accept}};
        o_rsp_valid = rsp_valid;
        o_rsp_data  = rsp_data_q;
        o_busy      = (|rsp_valid) | (|i_req_valid);
    end

    // Requesters must hold op/a/b while waiting; at most one grant per cycle.
    for (genvar k = 0; k < NREQ; k++) begin : g_chk
        a_req_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            (i_req_valid[k] && !o_req_ready[k]) |=>
                ($stable(i_req_op[k*ALUOP_WIDTH +: ALUOP_WIDTH]) &&
                 $stable(i_req_a[k*32 +: 32]) && $stable(i_req_b[k*32 +: 32])));
    end

    a_ready_onehot: assert property (@(posedge i_clk) $onehot0(o_req_ready));

endmodule
